// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end: default datapath width,
// reset vector and the fetch-stage state encoding.
package cpu_pkg;

    localparam int              CPU_WIDTH        = 16;
    localparam logic [15:0]     CPU_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. A branch load has priority over the
// post-delivery increment; otherwise the value holds. The next-state value
// is exported so the fetch FSM can latch the address of a back-to-back
// request in the same edge that advances the PC.
module pc_reg #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               PC_INC       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pc_d_o,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next PC: branch load, else wrap-around increment, else hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + WIDTH'(PC_INC);
        end
    end

    // PC storage with asynchronous reset to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_d_o = pc_d;
    assign pc_o   = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
//
//   state | meaning
//   IDLE  | first cycle out of reset, no request yet
//   REQ   | request outstanding at imem_addr, waiting for imem_ack
//   HOLD  | stalled between requests, imem_req low
//
// A branch while a request is outstanding sets flush so the word that is
// still in flight at the old address gets dropped when its ack returns.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = CPU_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(CPU_RESET_VECTOR),
    parameter int               PC_INC       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic             flush_q;
    logic             imem_req_q;
    logic [WIDTH-1:0] imem_addr_q;
    logic             instr_valid_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instr_pc_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    logic ack_acc;
    logic deliver;
    logic start_req;

    // Acks are only honoured while a request is actually outstanding.
    assign ack_acc   = (state_q == REQ) && imem_ack;
    assign deliver   = ack_acc && !flush_q && !branch_en;
    assign start_req = (state_d == REQ) && ((state_q != REQ) || ack_acc);

    pc_reg #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
        .PC_INC       (PC_INC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (branch_en),
        .load_val_i (branch_target),
        .inc_i      (deliver),
        .pc_d_o     (pc_d),
        .pc_o       (pc_q)
    );

    // Next fetch state; stall only gates the start of a new request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = stall ? HOLD : REQ;
            REQ:     if (imem_ack) state_d = stall ? HOLD : REQ;
            HOLD:    state_d = stall ? HOLD : REQ;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, flush tracking and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            flush_q       <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_VECTOR;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= (state_d == REQ);
            instr_valid_q <= deliver;
            if (start_req) begin
                imem_addr_q <= pc_d;
            end
            if (deliver) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_q;
            end
            if (ack_acc) begin
                flush_q <= 1'b0;
            end else if (branch_en && (state_q == REQ)) begin
                flush_q <= 1'b1;
            end
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for the fetch stage: sequential fetch, stall, branch with
// in-flight flush, branch on the ack cycle, PC wrap and mid-fetch reset.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_en;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc;

    int checks;
    int errors;

    pc_fetch_unit #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000),
        .PC_INC       (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; returns on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single-cycle ack strobe with the given read data.
    task automatic ack_cycle(input logic [15:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        step(); step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h exp 0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc: got %h exp 0000", instr_pc); end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req0: got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL seq_addr0: got %h exp 0000", imem_addr); end
        step();
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL seq_addr0_hold: got %h exp 0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_no_valid: got %b exp 0", instr_valid); end
        ack_cycle(16'h1111);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid1: got %b exp 1", instr_valid); end
        checks++; if (instr !== 16'h1111) begin errors++; $display("FAIL seq_instr1: got %h exp 1111", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL seq_ipc1: got %h exp 0000", instr_pc); end
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL seq_addr1: got %h exp 0001", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req1: got %b exp 1", imem_req); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_pulse_width: got %b exp 0", instr_valid); end
        ack_cycle(16'h2222);
        checks++; if (instr !== 16'h2222) begin errors++; $display("FAIL seq_instr2: got %h exp 2222", instr); end
        checks++; if (instr_pc !== 16'h0001) begin errors++; $display("FAIL seq_ipc2: got %h exp 0001", instr_pc); end
        checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL seq_pc2: got %h exp 0002", pc); end
    endtask

    task automatic test_stall();
        step();
        ack_cycle(16'h3333);
        checks++; if (imem_addr !== 16'h0003) begin errors++; $display("FAIL stall_addr3: got %h exp 0003", imem_addr); end
        stall = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_no_abort: got %b exp 1", imem_req); end
        ack_cycle(16'h4444);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b exp 1", instr_valid); end
        checks++; if (instr_pc !== 16'h0003) begin errors++; $display("FAIL stall_ipc: got %h exp 0003", instr_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %b exp 0", imem_req); end
        checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL stall_pc: got %h exp 0004", pc); end
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_held: got %b exp 0", imem_req); end
        stall = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_resume_req: got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_resume_addr: got %h exp 0004", imem_addr); end
    endtask

    task automatic test_branch_flush();
        step();
        ack_cycle(16'h5555);
        checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL flush_addr5: got %h exp 0005", imem_addr); end
        branch_en = 1'b1; branch_target = 16'h0040;
        step();
        branch_en = 1'b0; branch_target = 16'h0000;
        checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL flush_pc: got %h exp 0040", pc); end
        checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL flush_addr_kept: got %h exp 0005", imem_addr); end
        step();
        ack_cycle(16'hDEAD);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h5555) begin errors++; $display("FAIL flush_instr_held: got %h exp 5555", instr); end
        checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL flush_next_addr: got %h exp 0040", imem_addr); end
        checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL flush_pc_after: got %h exp 0040", pc); end
        step();
        ack_cycle(16'h6666);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL flush_cleared: got %b exp 1", instr_valid); end
        checks++; if (instr_pc !== 16'h0040) begin errors++; $display("FAIL flush_ipc40: got %h exp 0040", instr_pc); end
    endtask

    task automatic test_branch_on_ack();
        branch_en = 1'b1; branch_target = 16'h0080;
        ack_cycle(16'hBEEF);
        branch_en = 1'b0; branch_target = 16'h0000;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bra_ack_valid: got %b exp 0", instr_valid); end
        checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL bra_ack_pc: got %h exp 0080", pc); end
        checks++; if (imem_addr !== 16'h0080) begin errors++; $display("FAIL bra_ack_addr: got %h exp 0080", imem_addr); end
        checks++; if (instr !== 16'h6666) begin errors++; $display("FAIL bra_ack_instr: got %h exp 6666", instr); end
    endtask

    task automatic test_wrap();
        branch_en = 1'b1; branch_target = 16'hFFFF;
        ack_cycle(16'h7777);
        branch_en = 1'b0; branch_target = 16'h0000;
        checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h exp ffff", imem_addr); end
        ack_cycle(16'h1234);
        checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL wrap_instr: got %h exp 1234", instr); end
        checks++; if (instr_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_ipc: got %h exp ffff", instr_pc); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h exp 0000", pc); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr: got %h exp 0000", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        branch_en = 1'b1; branch_target = 16'h0042;
        ack_cycle(16'h8888);
        branch_en = 1'b0; branch_target = 16'h0000;
        checks++; if (imem_addr !== 16'h0042) begin errors++; $display("FAIL rst_pre_addr: got %h exp 0042", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b exp 1", imem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_async_addr: got %h exp 0000", imem_addr); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_async_pc: got %h exp 0000", pc); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_async_instr: got %h exp 0000", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_async_ipc: got %h exp 0000", instr_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_cycle(16'h9999);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_first_addr: got %h exp 0000", imem_addr); end
        ack_cycle(16'hAAAA);
        checks++; if (instr !== 16'hAAAA) begin errors++; $display("FAIL rst_first_instr: got %h exp aaaa", instr); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL rst_first_pc: got %h exp 0001", pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_flush();
        test_branch_on_ack();
        test_wrap();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
